stage_2_nbool: RTL and testbench

Parametrised, registered Stage 2 of the AV1 entropy encoder. Per accepted request it either finishes one CDF (Q15) symbol or runs a burst of up to `MAX_BOOL` 50 %-probability Booleans, evaluating `LANES` chained Boolean steps per cycle. The block owns the normalised range register, emits one-round-normalised results, and sits between Stage 1 (valid/ready upstream) and Stage 3 (valid/ready downstream).

---
 rtl/stage_2_pkg.sv | 25 ++
 rtl/lzc_miao_16.sv | 17 +
 rtl/s2n_bool_lane.sv | 35 +++
 rtl/stage_2_nbool.sv | 263 ++++++++++++++++++++++++++
 tb/tb_stage_2_nbool.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_2_pkg.sv
// stage_2_pkg: shared definitions for the AV1 entropy-encoder Stage 2.
//   - request mode encodings
//   - FSM state type
//   - range constants for INIT and the Boolean v offset
//   - helper giving how many Boolean lanes a beat consumes
package stage_2_pkg;

    localparam logic [1:0] MODE_CDF  = 2'b00;
    localparam logic [1:0] MODE_BOOL = 2'b01;
    localparam logic [1:0] MODE_INIT = 2'b10;

    localparam logic [15:0] INIT_RANGE    = 16'h8000;
    localparam int          BOOL_V_OFFSET = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of Boolean steps issued in one beat: min(remaining, lanes).
    function automatic int lanes_this_beat(input int remaining, input int lanes);
        return (remaining < lanes) ? remaining : lanes;
    endfunction

endpackage

// File: rtl/lzc_miao_16.sv
// lzc_miao_16: 16-bit leading-zero counter used to renormalise the CDF range.
//   data_in  : value to inspect
//   lz_count : number of leading zeros (16 when data_in is zero)
module lzc_miao_16 (
    input  logic [15:0] data_in,
    output logic [4:0]  lz_count
);

    // Scan from LSB to MSB so the highest set bit writes last and wins.
    always_comb begin
        lz_count = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (data_in[i]) lz_count = 5'(15 - i);
        end
    end

endmodule

// File: rtl/s2n_bool_lane.sv
// s2n_bool_lane: one combinational 50 %-probability Boolean coding step.
//   r_in   : incoming normalised range
//   bit_in : Boolean symbol
//   p      : r_in - v (the "low" pre-calculation for this step)
//   d      : normalisation shift (0..2)
//   r_out  : renormalised range raw << d
module s2n_bool_lane
    import stage_2_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5
) (
    input  logic [RANGE_WIDTH-1:0] r_in,
    input  logic                   bit_in,
    output logic [RANGE_WIDTH-1:0] p,
    output logic [D_SIZE-1:0]      d,
    output logic [RANGE_WIDTH-1:0] r_out
);

    logic [RANGE_WIDTH-1:0] v;
    logic [RANGE_WIDTH-1:0] raw;

    always_comb begin
        v   = ((r_in >> 8) << 7) + RANGE_WIDTH'(BOOL_V_OFFSET);
        p   = r_in - v;
        raw = bit_in ? v : p;
        // Either branch is at least a quarter of a normalised range,
        // so at most two shifts restore the MSB.
        if (raw[RANGE_WIDTH-1])      d = D_SIZE'(0);
        else if (raw[RANGE_WIDTH-2]) d = D_SIZE'(1);
        else                         d = D_SIZE'(2);
        r_out = raw << d;
    end

endmodule

// File: rtl/stage_2_nbool.sv
// stage_2_nbool: registered Stage 2 of the AV1 entropy encoder.
// Each accepted request finishes one CDF symbol, runs a burst of up to
// MAX_BOOL Booleans (LANES per beat), or re-initialises the range.
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : request handshake from Stage 1
//   in_mode, in_comp_mux_1     : request type and CDF branch select
//   in_count, in_bits          : Boolean burst length and symbols (bit 0 first)
//   UU, VV, lut_u, lut_v, lut_uv : CDF operands
//   out_valid/out_ready        : beat handshake to Stage 3
//   out_mode, out_comp_mux_1, out_last, out_count, out_bits : beat tags
//   u, out_d, pre_calc_low, initial_range, out_range        : beat data
//   dbg_state                  : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready; a
// source holds valid and its payload stable until that edge.
module stage_2_nbool
    import stage_2_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5,
    parameter int MAX_BOOL    = 8,
    parameter int LANES       = 3,
    parameter int CW          = $clog2(MAX_BOOL + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_mode,
    input  logic                         in_comp_mux_1,
    input  logic [CW-1:0]                in_count,
    input  logic [MAX_BOOL-1:0]          in_bits,
    input  logic [RANGE_WIDTH-1:0]       UU,
    input  logic [RANGE_WIDTH-1:0]       VV,
    input  logic [RANGE_WIDTH-1:0]       lut_u,
    input  logic [RANGE_WIDTH-1:0]       lut_v,
    input  logic [RANGE_WIDTH-1:0]       lut_uv,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_mode,
    output logic                         out_comp_mux_1,
    output logic                         out_last,
    output logic [CW-1:0]                out_count,
    output logic [LANES-1:0]             out_bits,
    output logic [RANGE_WIDTH:0]         u,
    output logic [LANES*D_SIZE-1:0]      out_d,
    output logic [LANES*RANGE_WIDTH-1:0] pre_calc_low,
    output logic [LANES*RANGE_WIDTH-1:0] initial_range,
    output logic [RANGE_WIDTH-1:0]       out_range,
    output state_e                       dbg_state
);

    // ---------------- state ----------------
    state_e                       state_q, state_d;
    logic [RANGE_WIDTH-1:0]       range_q, range_d;
    logic [CW-1:0]                rem_q, rem_d;
    logic [MAX_BOOL-1:0]          bits_q, bits_d;
    logic                         comp_q, comp_d;
    logic                         out_valid_q, out_valid_d;
    logic [1:0]                   out_mode_q, out_mode_d;
    logic                         out_comp_q, out_comp_d;
    logic                         out_last_q, out_last_d;
    logic [CW-1:0]                out_count_q, out_count_d;
    logic [LANES-1:0]             out_bits_q, out_bits_d;
    logic [RANGE_WIDTH:0]         u_q, u_d;
    logic [LANES*D_SIZE-1:0]      out_d_q, out_d_d;
    logic [LANES*RANGE_WIDTH-1:0] pcl_q, pcl_d;
    logic [LANES*RANGE_WIDTH-1:0] init_r_q, init_r_d;
    logic [RANGE_WIDTH-1:0]       out_range_q, out_range_d;

    // ---------------- control signals ----------------
    logic                adv, load;
    logic [1:0]          eff_mode;
    logic [MAX_BOOL-1:0] src_bits;
    int                  src_n, take;

    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = (state_q == ST_IDLE) && adv;
        load     = adv && ((state_q == ST_RUN) || in_valid);
        if (state_q == ST_RUN) begin
            eff_mode = MODE_BOOL;
            src_bits = bits_q;
            src_n    = int'(rem_q);
        end else begin
            // Reserved mode 11 behaves as INIT.
            eff_mode = (in_mode == MODE_CDF || in_mode == MODE_BOOL) ? in_mode : MODE_INIT;
            src_bits = in_bits;
            src_n    = (int'(in_count) > MAX_BOOL) ? MAX_BOOL : int'(in_count);
        end
        take = lanes_this_beat(src_n, LANES);
    end

    // ---------------- Boolean lane chain ----------------
    logic [RANGE_WIDTH-1:0] chain_r [LANES+1];
    logic [RANGE_WIDTH-1:0] lane_p  [LANES];
    logic [RANGE_WIDTH-1:0] lane_r  [LANES];
    logic [D_SIZE-1:0]      lane_d  [LANES];
    logic [LANES-1:0]       lane_en;

    assign chain_r[0] = range_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        s2n_bool_lane #(
            .RANGE_WIDTH(RANGE_WIDTH),
            .D_SIZE     (D_SIZE)
        ) u_lane (
            .r_in  (chain_r[g]),
            .bit_in(src_bits[g]),
            .p     (lane_p[g]),
            .d     (lane_d[g]),
            .r_out (lane_r[g])
        );
        assign lane_en[g]     = (g < take);
        // Idle lanes pass the range through untouched.
        assign chain_r[g + 1] = lane_en[g] ? lane_r[g] : chain_r[g];
    end

    // ---------------- CDF datapath ----------------
    logic [RANGE_WIDTH-9:0] rr;
    logic [RANGE_WIDTH+1:0] prod_t, prod_v;
    logic [RANGE_WIDTH:0]   cdf_t, cdf_v, cdf_u;
    logic [RANGE_WIDTH-1:0] cdf_raw, cdf_r;
    logic [4:0]             cdf_lz;
    logic                   unused_hi;

    assign unused_hi = ^{UU[RANGE_WIDTH-1:10], VV[RANGE_WIDTH-1:10]};

    always_comb begin
        rr      = range_q[RANGE_WIDTH-1:8];
        prod_t  = (RANGE_WIDTH+2)'(rr) * (RANGE_WIDTH+2)'(UU[9:0]);
        prod_v  = (RANGE_WIDTH+2)'(rr) * (RANGE_WIDTH+2)'(VV[9:0]);
        cdf_t   = (RANGE_WIDTH+1)'(prod_t >> 1);
        cdf_v   = (RANGE_WIDTH+1)'(prod_v >> 1);
        cdf_u   = cdf_t + {1'b0, lut_u};
        cdf_raw = in_comp_mux_1 ? RANGE_WIDTH'(cdf_t - cdf_v + {1'b0, lut_uv})
                                : RANGE_WIDTH'({1'b0, range_q} - {1'b0, lut_v} - cdf_v);
        cdf_r   = cdf_raw << cdf_lz;
    end

    lzc_miao_16 u_lzc (
        .data_in (cdf_raw),
        .lz_count(cdf_lz)
    );

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_d     = state_q;
        range_d     = range_q;
        rem_d       = rem_q;
        bits_d      = bits_q;
        comp_d      = comp_q;
        out_valid_d = out_valid_q;
        out_mode_d  = out_mode_q;
        out_comp_d  = out_comp_q;
        out_last_d  = out_last_q;
        out_count_d = out_count_q;
        out_bits_d  = out_bits_q;
        u_d         = u_q;
        out_d_d     = out_d_q;
        pcl_d       = pcl_q;
        init_r_d    = init_r_q;
        out_range_d = out_range_q;

        if (adv) out_valid_d = load;

        if (load) begin
            out_mode_d  = eff_mode;
            out_comp_d  = (state_q == ST_RUN) ? comp_q : in_comp_mux_1;
            out_count_d = '0;
            out_bits_d  = '0;
            u_d         = '0;
            out_d_d     = '0;
            pcl_d       = '0;
            init_r_d    = '0;
            out_last_d  = 1'b1;
            state_d     = ST_IDLE;
            case (eff_mode)
                MODE_CDF: begin
                    u_d                        = cdf_u;
                    out_d_d[D_SIZE-1:0]        = D_SIZE'(cdf_lz);
                    pcl_d[RANGE_WIDTH-1:0]     = range_q - RANGE_WIDTH'(cdf_v);
                    init_r_d[RANGE_WIDTH-1:0]  = range_q;
                    out_range_d                = cdf_r;
                    range_d                    = cdf_r;
                end
                MODE_BOOL: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_en[i]) begin
                            out_bits_d[i]                          = src_bits[i];
                            out_d_d[i*D_SIZE +: D_SIZE]            = lane_d[i];
                            pcl_d[i*RANGE_WIDTH +: RANGE_WIDTH]    = lane_p[i];
                            init_r_d[i*RANGE_WIDTH +: RANGE_WIDTH] = chain_r[i];
                        end
                    end
                    out_count_d = CW'(take);
                    out_range_d = chain_r[LANES];
                    range_d     = chain_r[LANES];
                    rem_d       = CW'(src_n - take);
                    bits_d      = src_bits >> take;
                    out_last_d  = (src_n == take);
                    if (state_q == ST_IDLE) comp_d = in_comp_mux_1;
                    if (src_n != take) state_d = ST_RUN;
                end
                default: begin
                    out_range_d = INIT_RANGE;
                    range_d     = INIT_RANGE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            range_q     <= INIT_RANGE;
            rem_q       <= '0;
            bits_q      <= '0;
            comp_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_mode_q  <= '0;
            out_comp_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_count_q <= '0;
            out_bits_q  <= '0;
            u_q         <= '0;
            out_d_q     <= '0;
            pcl_q       <= '0;
            init_r_q    <= '0;
            out_range_q <= '0;
        end else begin
            state_q     <= state_d;
            range_q     <= range_d;
            rem_q       <= rem_d;
            bits_q      <= bits_d;
            comp_q      <= comp_d;
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            out_comp_q  <= out_comp_d;
            out_last_q  <= out_last_d;
            out_count_q <= out_count_d;
            out_bits_q  <= out_bits_d;
            u_q         <= u_d;
            out_d_q     <= out_d_d;
            pcl_q       <= pcl_d;
            init_r_q    <= init_r_d;
            out_range_q <= out_range_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_mode       = out_mode_q;
    assign out_comp_mux_1 = out_comp_q;
    assign out_last       = out_last_q;
    assign out_count      = out_count_q;
    assign out_bits       = out_bits_q;
    assign u              = u_q;
    assign out_d          = out_d_q;
    assign pre_calc_low   = pcl_q;
    assign initial_range  = init_r_q;
    assign out_range      = out_range_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_stage_2_nbool.sv
// tb_stage_2_nbool: directed self-checking bench for stage_2_nbool
// (RANGE_WIDTH 16, D_SIZE 5, MAX_BOOL 8, LANES 3).
module tb_stage_2_nbool;
    import stage_2_pkg::*;

    localparam int RW = 16;
    localparam int DS = 5;
    localparam int MB = 8;
    localparam int LN = 3;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, in_comp_mux_1;
    logic [1:0]        in_mode;
    logic [CW-1:0]     in_count;
    logic [MB-1:0]     in_bits;
    logic [RW-1:0]     uu, vv, lut_u, lut_v, lut_uv;
    logic              out_valid, out_ready, out_comp_mux_1, out_last;
    logic [1:0]        out_mode;
    logic [CW-1:0]     out_count;
    logic [LN-1:0]     out_bits;
    logic [RW:0]       u;
    logic [LN*DS-1:0]  out_d;
    logic [LN*RW-1:0]  pre_calc_low, initial_range;
    logic [RW-1:0]     out_range;
    state_e            dbg_state;

    stage_2_nbool #(
        .RANGE_WIDTH(RW), .D_SIZE(DS), .MAX_BOOL(MB), .LANES(LN)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_comp_mux_1(in_comp_mux_1),
        .in_count(in_count), .in_bits(in_bits),
        .UU(uu), .VV(vv), .lut_u(lut_u), .lut_v(lut_v), .lut_uv(lut_uv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_comp_mux_1(out_comp_mux_1), .out_last(out_last),
        .out_count(out_count), .out_bits(out_bits), .u(u), .out_d(out_d),
        .pre_calc_low(pre_calc_low), .initial_range(initial_range),
        .out_range(out_range), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] mode, input logic comp, input int n,
                            input logic [MB-1:0] bits, input logic [RW-1:0] a_uu,
                            input logic [RW-1:0] a_vv, input logic [RW-1:0] a_lu,
                            input logic [RW-1:0] a_lv, input logic [RW-1:0] a_luv);
        int waited;
        in_mode       = mode;
        in_comp_mux_1 = comp;
        in_count      = CW'(n);
        in_bits       = bits;
        uu = a_uu; vv = a_vv; lut_u = a_lu; lut_v = a_lv; lut_uv = a_luv;
        in_valid      = 1'b1;
        waited        = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_bool(input int n, input logic [MB-1:0] bits);
        send_req(MODE_BOOL, 1'b0, n, bits, '0, '0, '0, '0, '0);
    endtask

    task automatic wait_beat();
        int waited = 0;
        while (!out_valid && waited < 50) begin
            tick();
            waited++;
        end
        if (!out_valid) check_eq("beat_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic check_beat(input string tag, input int cnt, input logic [LN-1:0] bits,
                              input int rng, input logic last);
        wait_beat();
        check_eq({tag, "_count"}, 64'(out_count), 64'(cnt));
        check_eq({tag, "_bits"},  64'(out_bits),  64'(bits));
        check_eq({tag, "_range"}, 64'(out_range), 64'(rng));
        check_eq({tag, "_last"},  64'(out_last),  64'(last));
    endtask

    task automatic do_init(input string tag);
        send_req(MODE_INIT, 1'b0, 0, '0, '0, '0, '0, '0, '0);
        check_beat(tag, 0, '0, 32768, 1'b1);
        check_eq({tag, "_mode"}, 64'(out_mode), 64'(MODE_INIT));
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_mode = '0; in_comp_mux_1 = 1'b0; in_count = '0; in_bits = '0;
        uu = '0; vv = '0; lut_u = '0; lut_v = '0; lut_uv = '0;
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_range", 64'(out_range), 64'd0);
        check_eq("rst_state",     64'(dbg_state), 64'(ST_IDLE));

        // single Boolean, bit 0, from 0x8000
        send_bool(1, 8'b0);
        check_beat("b0", 1, 3'b000, 65520, 1'b1);
        check_eq("b0_init_r", 64'(initial_range[15:0]), 64'd32768);
        check_eq("b0_pcl",    64'(pre_calc_low[15:0]),  64'd16380);
        check_eq("b0_d",      64'(out_d[4:0]),          64'd2);
        tick();

        // single Boolean, bit 1, after INIT
        do_init("init1");
        send_bool(1, 8'b1);
        check_beat("b1", 1, 3'b001, 32776, 1'b1);
        check_eq("b1_d", 64'(out_d[4:0]), 64'd1);
        tick();

        // five Booleans across two beats
        do_init("init2");
        send_bool(5, 8'b0001_0110);
        check_beat("burst1", 3, 3'b110, 65288, 1'b0);
        check_eq("burst1_in_ready", 64'(in_ready), 64'd0);
        check_eq("burst1_d",        64'(out_d),    64'd1058);
        check_eq("burst1_pcl0", 64'(pre_calc_low[15:0]),  64'd16380);
        check_eq("burst1_pcl1", 64'(pre_calc_low[31:16]), 64'd32876);
        check_eq("burst1_pcl2", 64'(pre_calc_low[47:32]), 64'd32644);
        check_eq("burst1_ir1",  64'(initial_range[31:16]), 64'd65520);
        tick();
        check_beat("burst2", 2, 3'b010, 65288, 1'b1);
        check_eq("burst2_d", 64'(out_d), 64'd33);
        tick();
        check_eq("burst_done_valid", 64'(out_valid), 64'd0);
        check_eq("burst_done_ready", 64'(in_ready),  64'd1);

        // CDF, comp 0
        do_init("init3");
        send_req(MODE_CDF, 1'b0, 0, '0, 16'd0, 16'd0, 16'd123, 16'd4, 16'd0);
        check_beat("cdf0", 0, 3'b000, 65528, 1'b1);
        check_eq("cdf0_d", 64'(out_d[4:0]), 64'd1);
        check_eq("cdf0_u", 64'(u),          64'd123);
        tick();

        // CDF, comp 1: t=6400, v=3200, raw=4200 -> lzc 3
        do_init("init4");
        send_req(MODE_CDF, 1'b1, 0, '0, 16'd100, 16'd50, 16'd10, 16'd0, 16'd1000);
        check_beat("cdf1", 0, 3'b000, 33600, 1'b1);
        check_eq("cdf1_d",    64'(out_d[4:0]),    64'd3);
        check_eq("cdf1_u",    64'(u),             64'd6410);
        check_eq("cdf1_comp", 64'(out_comp_mux_1), 64'd1);
        tick();

        // zero-length Boolean leaves range unchanged
        send_bool(0, 8'hFF);
        check_beat("bool_n0", 0, 3'b000, 33600, 1'b1);
        tick();

        // backpressure mid-burst
        do_init("init5");
        out_ready = 1'b0;
        send_bool(5, 8'b0001_0110);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_valid", 64'(out_valid), 64'd1);
            check_eq("stall_range", 64'(out_range), 64'd65288);
            check_eq("stall_count", 64'(out_count), 64'd3);
            tick();
        end
        out_ready = 1'b1;
        check_beat("stall1", 3, 3'b110, 65288, 1'b0);
        tick();
        check_beat("stall2", 2, 3'b010, 65288, 1'b1);
        tick();
        check_eq("stall_done_valid", 64'(out_valid), 64'd0);

        // count above MAX_BOOL is clamped to 8 -> 3, 3, 2
        do_init("init6");
        send_bool(15, 8'b0);
        wait_beat();
        check_eq("clamp_c1", 64'(out_count), 64'd3);
        check_eq("clamp_l1", 64'(out_last),  64'd0);
        tick();
        check_eq("clamp_c2", 64'(out_count), 64'd3);
        check_eq("clamp_l2", 64'(out_last),  64'd0);
        tick();
        check_eq("clamp_c3", 64'(out_count), 64'd2);
        check_eq("clamp_l3", 64'(out_last),  64'd1);
        tick();

        // reset during RUN drops the burst
        do_init("init7");
        send_bool(8, 8'b0);
        wait_beat();
        check_eq("rrun_state", 64'(dbg_state), 64'(ST_RUN));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rrun_valid", 64'(out_valid), 64'd0);
        check_eq("rrun_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        check_eq("rrun_no_leak", 64'(out_valid), 64'd0);
        send_bool(1, 8'b0);
        check_beat("rrun_b0", 1, 3'b000, 65520, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
